// File: rtl/ins_prefetch_queue.sv
// Instruction prefetch unit feeding decode: PC generator, single-outstanding
// request/ack memory port, and a DEPTH-entry FIFO of {instruction, pc}.
module ins_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] entryPoint,
  input  logic        INT,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  output logic [31:0] pc_plus4
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t        state, state_nx;
  logic [31:0]   fetch_pc, drain_addr;
  logic [31:0]   ins_q [DEPTH];
  logic [31:0]   pc_q  [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, free;
  logic          flush, head_pop, pop, push;
  logic [31:0]   flush_target;

  assign flush        = INT | redirect;
  assign flush_target = (INT ? entryPoint : redirect_pc) & ~32'h3;
  assign head_pop     = ins_valid & ins_ready;
  assign pop          = head_pop & ~flush;
  assign push         = (state == REQ) & mem_ack & ~flush;
  // Slots available once this cycle's pop has retired.
  assign free         = CW'(DEPTH) - count + CW'(head_pop);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      // A request already on the bus must complete before a new one may issue.
      unique case (state)
        IDLE:    state_nx = IDLE;
        REQ:     state_nx = mem_ack ? IDLE : DRAIN;
        DRAIN:   state_nx = mem_ack ? IDLE : DRAIN;
        default: state_nx = IDLE;
      endcase
    end else begin
      unique case (state)
        IDLE:    if (free != '0) state_nx = REQ;
        REQ:     if (mem_ack) state_nx = (free > CW'(1)) ? REQ : IDLE;
        DRAIN:   if (mem_ack) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req  = (state == REQ) || (state == DRAIN);
    mem_addr = (state == DRAIN) ? drain_addr : fetch_pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc   <= RESET_PC & ~32'h3;
      drain_addr <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else if (flush) begin
      fetch_pc <= flush_target;
      if (state == REQ && !mem_ack) drain_addr <= fetch_pc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + AW'(1);
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ins_q[wr_ptr] <= mem_rdata;
      pc_q[wr_ptr]  <= fetch_pc;
    end
  end

  always_comb begin
    ins_valid = (count != '0);
    ins       = ins_valid ? ins_q[rd_ptr] : '0;
    ins_pc    = ins_valid ? pc_q[rd_ptr]  : '0;
    pc_plus4  = ins_pc + 32'd4;
  end

endmodule

// File: tb/tb_ins_prefetch_queue.sv
// Directed bench for ins_prefetch_queue; memory returns word = address.
module tb_ins_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset, INT, redirect, mem_ack, ins_ready;
  logic [31:0] entryPoint, redirect_pc;
  logic        mem_req, ins_valid;
  logic [31:0] mem_addr, mem_rdata, ins, ins_pc, pc_plus4;

  int vectors     = 0;
  int miscompares = 0;
  int xfers;
  logic [31:0] exp_addr, exp_pop;

  always #5 clk = ~clk;

  assign mem_rdata = mem_addr;

  ins_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .entryPoint(entryPoint), .INT(INT),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ins(ins), .ins_pc(ins_pc), .pc_plus4(pc_plus4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; INT = 1'b0; redirect = 1'b0; mem_ack = 1'b0; ins_ready = 1'b0;
    entryPoint = '0; redirect_pc = '0;

    // Reset state
    tick();
    chk("rst_req",   32'(mem_req),   32'd0);
    chk("rst_valid", 32'(ins_valid), 32'd0);
    chk("rst_ins",   ins,            32'h0);
    chk("rst_pc",    ins_pc,         32'h0);
    chk("rst_pc4",   pc_plus4,       32'h4);

    // Entry at 0x28, then streaming one instruction per cycle
    reset = 1'b0; INT = 1'b1; entryPoint = 32'h28; mem_ack = 1'b1; ins_ready = 1'b1;
    tick();
    INT = 1'b0;
    chk("ent_idle_req", 32'(mem_req),   32'd0);
    chk("ent_idle_vld", 32'(ins_valid), 32'd0);
    tick();
    chk("ent_req",  32'(mem_req),   32'd1);
    chk("ent_addr", mem_addr,       32'h28);
    chk("ent_vld0", 32'(ins_valid), 32'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("str_vld", 32'(ins_valid), 32'd1);
      chk("str_pc",  ins_pc,   32'h28 + 32'(4 * k));
      chk("str_ins", ins,      32'h28 + 32'(4 * k));
      chk("str_pc4", pc_plus4, 32'h2C + 32'(4 * k));
      tick();
    end

    // Backpressure: refill from 0x28 with decode stalled
    INT = 1'b1; entryPoint = 32'h28; ins_ready = 1'b0;
    tick();
    INT = 1'b0;
    xfers = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req && mem_ack) xfers++;
      tick();
    end
    chk("bp_xfers", 32'(xfers),     32'd4);
    chk("bp_req",   32'(mem_req),   32'd0);
    chk("bp_vld",   32'(ins_valid), 32'd1);
    chk("bp_head",  ins_pc,         32'h28);
    chk("bp_ins",   ins,            32'h28);
    ins_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("rel_vld", 32'(ins_valid), 32'd1);
      chk("rel_pc",  ins_pc, 32'h28 + 32'(4 * k));
      tick();
    end

    // Redirect while a request is outstanding
    mem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h103;
    chk("drn_pre_addr", mem_addr, 32'h54);
    tick();
    redirect = 1'b0;
    chk("drn_req",  32'(mem_req),   32'd1);
    chk("drn_addr", mem_addr,       32'h54);
    chk("drn_vld",  32'(ins_valid), 32'd0);
    tick();
    chk("drn_hold", mem_addr, 32'h54);
    mem_ack = 1'b1;
    tick();
    chk("drn_done_req", 32'(mem_req),   32'd0);
    chk("drn_discard",  32'(ins_valid), 32'd0);
    tick();
    chk("rd_req",  32'(mem_req), 32'd1);
    chk("rd_addr", mem_addr,     32'h100);

    // Slow memory: ack every third cycle
    exp_addr = 32'h100; exp_pop = 32'h100;
    for (int i = 0; i < 12; i++) begin
      mem_ack = (i % 3 == 2);
      chk("slow_req",  32'(mem_req), 32'd1);
      chk("slow_addr", mem_addr,     exp_addr);
      if (ins_valid) chk("slow_pc", ins_pc, exp_pop);
      if (mem_req && mem_ack) exp_addr += 32'd4;
      if (ins_valid && ins_ready) exp_pop += 32'd4;
      tick();
    end
    chk("slow_npop", exp_pop,  32'h10C);
    chk("slow_nxt",  exp_addr, 32'h110);

    // Redirect + transfer + pop together
    mem_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
    chk("co_pre_vld", 32'(ins_valid), 32'd1);
    tick();
    redirect = 1'b0;
    chk("co_vld", 32'(ins_valid), 32'd0);
    chk("co_req", 32'(mem_req),   32'd0);
    chk("co_ins", ins,            32'h0);
    tick();
    chk("co_addr", mem_addr, 32'h300);

    // INT and redirect together: entry point wins
    INT = 1'b1; entryPoint = 32'h400; redirect = 1'b1; redirect_pc = 32'h500; ins_ready = 1'b0;
    tick();
    INT = 1'b0; redirect = 1'b0;
    chk("ir_vld", 32'(ins_valid), 32'd0);
    tick();
    chk("ir_addr", mem_addr, 32'h400);
    tick();
    chk("ir_head", ins_pc, 32'h400);

    // Reset with three entries queued
    tick();
    tick();
    chk("q3_vld",  32'(ins_valid), 32'd1);
    chk("q3_head", ins_pc,         32'h400);
    chk("q3_addr", mem_addr,       32'h40C);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_vld", 32'(ins_valid), 32'd0);
    chk("mr_req", 32'(mem_req),   32'd0);
    chk("mr_ins", ins,            32'h0);
    chk("mr_pc",  ins_pc,         32'h0);
    chk("mr_pc4", pc_plus4,       32'h4);
    tick();
    chk("mr_restart", mem_addr, 32'h0);

    // Wrap at the top of the address space
    INT = 1'b1; entryPoint = 32'hFFFF_FFFC;
    tick();
    INT = 1'b0;
    tick();
    chk("wr_addr", mem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wr_pc",   ins_pc,   32'hFFFF_FFFC);
    chk("wr_ins",  ins,      32'hFFFF_FFFC);
    chk("wr_pc4",  pc_plus4, 32'h0);
    chk("wr_next", mem_addr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
